alu_mc: RTL and testbench

//  Multi-cycle, width-parametrised ALU for the next-generation datapath.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_iter_unit.sv | 85 ++++++++
 rtl/alu_mc.sv | 126 ++++++++++++
 tb/tb_alu_mc.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and helper definitions for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_MUL  = 4'b1000;
    localparam logic [3:0] ALU_DIVU = 4'b1001;
    localparam logic [3:0] ALU_REMU = 4'b1010;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic is_multicycle(input logic [3:0] ctrl);
        return (ctrl == ALU_MUL) || (ctrl == ALU_DIVU) || (ctrl == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Shared iterative engine: shift-add multiplier and restoring unsigned divider,
// one bit per step, with a WIDTH-step counter.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mul_q, mul_d;
    logic             rem_q, rem_d;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             ge;

    // acc holds the product (MUL) or the partial remainder (DIV); a_q shifts the
    // dividend out at the top while quotient bits enter at the bottom.
    always_comb begin
        acc_d     = acc_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        mul_d     = mul_q;
        rem_d     = rem_q;
        rem_shift = {acc_q, a_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, b_q};
        ge        = ~trial[WIDTH];
        if (load_i) begin
            acc_d = '0;
            a_d   = a_i;
            b_d   = b_i;
            cnt_d = '0;
            mul_d = (op_i == ALU_MUL);
            rem_d = (op_i == ALU_REMU);
        end else if (step_i) begin
            cnt_d = cnt_q + CW'(1);
            if (mul_q) begin
                acc_d = acc_q + (b_q[0] ? a_q : '0);
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
            end else begin
                acc_d = ge ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                a_d   = {a_q[WIDTH-2:0], ge};
            end
        end
    end

    // A zero divisor always passes the trial subtract, giving all-ones / src1 naturally.
    assign result_o = (mul_q || rem_q) ? acc_d : a_d;
    assign last_o   = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            mul_q <= 1'b0;
            rem_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
            mul_q <= mul_d;
            rem_q <= rem_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: handshake FSM, single-cycle ops, overflow/zero flags and
// registered outputs around the shared iterative MUL/DIV engine.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1,
    parameter bit DIV_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             ovf_o
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic             accept;
    logic             go_iter;
    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             iter_last;
    logic [WIDTH-1:0] iter_result;

    assign ready_o = (state_q != ST_ITER);
    assign accept  = start_i && ready_o;
    assign go_iter = is_multicycle(ctrl_i) && ((ctrl_i == ALU_MUL) ? MUL_EN : DIV_EN);
    assign sum     = src1_i + src2_i;
    assign diff    = src1_i - src2_i;

    // Disabled MUL/DIV codes fall into the default arm and behave as illegal ops.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (ctrl_i)
            ALU_AND: alu_res = src1_i & src2_i;
            ALU_OR:  alu_res = src1_i | src2_i;
            ALU_NOR: alu_res = ~(src1_i | src2_i);
            ALU_ADD: begin
                alu_res = sum;
                alu_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = diff;
                alu_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (diff[WIDTH-1] != src1_i[WIDTH-1]);
            end
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            default: alu_res = '0;
        endcase
    end

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (accept && go_iter),
        .step_i   (state_q == ST_ITER),
        .op_i     (ctrl_i),
        .a_i      (src1_i),
        .b_i      (src2_i),
        .last_o   (iter_last),
        .result_o (iter_result)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        if (state_q == ST_ITER) begin
            if (iter_last) begin
                state_d  = ST_DONE;
                result_d = iter_result;
                zero_d   = (iter_result == '0);
                ovf_d    = 1'b0;
                done_d   = 1'b1;
            end
        end else if (accept) begin
            if (go_iter) begin
                state_d = ST_ITER;
            end else begin
                state_d  = ST_DONE;
                result_d = alu_res;
                zero_d   = (alu_res == '0);
                ovf_d    = alu_ovf;
                done_d   = 1'b1;
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign done_o   = done_q;
    assign result_o = result_q;
    assign zero_o   = zero_q;
    assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed, self-checking bench for alu_mc at WIDTH=32 with hand-computed expectations.
module tb_alu_mc;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  ctrl;
    logic [31:0] src1, src2;
    logic        ready, done, zero, ovf;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int n;
    logic sawDone;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32), .MUL_EN(1'b1), .DIV_EN(1'b1)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .ctrl_i   (ctrl),
        .src1_i   (src1),
        .src2_i   (src2),
        .ready_o  (ready),
        .done_o   (done),
        .result_o (result),
        .zero_o   (zero),
        .ovf_o    (ovf)
    );

    // Present one request, let it be taken on the next rising edge, then drop start.
    task automatic applyStimulus(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        ctrl  = c;
        src1  = a;
        src2  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Cycle index of done_o counted with the accept cycle as 1; bounded at 100.
    task automatic waitDone(output int cyc);
        cyc = 1;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        ctrl  = ALU_AND;
        src1  = '0;
        src2  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready",  32'(ready),  32'd1);
        checkOutput("rst_done",   32'(done),   32'd0);
        checkOutput("rst_result", result,      32'd0);
        checkOutput("rst_zero",   32'(zero),   32'd1);
        checkOutput("rst_ovf",    32'(ovf),    32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
        checkOutput("add_done",   32'(done), 32'd1);
        checkOutput("add_result", result,    32'h8000_0000);
        checkOutput("add_ovf",    32'(ovf),  32'd1);
        checkOutput("add_zero",   32'(zero), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("add_pulse",  32'(done),  32'd0);
        checkOutput("add_ready",  32'(ready), 32'd1);

        applyStimulus(ALU_SUB, 32'd5, 32'd5);
        checkOutput("sub_result", result,    32'd0);
        checkOutput("sub_zero",   32'(zero), 32'd1);
        checkOutput("sub_ovf",    32'(ovf),  32'd0);

        applyStimulus(ALU_SUB, 32'h8000_0000, 32'd1);
        checkOutput("subovf_result", result,   32'h7FFF_FFFF);
        checkOutput("subovf_ovf",    32'(ovf), 32'd1);

        applyStimulus(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        checkOutput("slt_result", result, 32'd1);
        applyStimulus(ALU_SLT, 32'd1, 32'hFFFF_FFFF);
        checkOutput("slt_rev_result", result, 32'd0);
        @(posedge clk);
        #1;

        // MUL with start left high and inputs scrambled during iteration.
        ctrl  = ALU_MUL;
        src1  = 32'hFFFF_FFFF;
        src2  = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        ctrl = ALU_ADD;
        src1 = 32'd1;
        src2 = 32'd1;
        checkOutput("mul_busy_ready", 32'(ready), 32'd0);
        checkOutput("mul_busy_done",  32'(done),  32'd0);
        waitDone(n);
        start = 1'b0;
        checkOutput("mul_latency", 32'(n),   32'd33);
        checkOutput("mul_result",  result,   32'hFFFF_FFFD);
        checkOutput("mul_ovf",     32'(ovf), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("mul_no_queue_done",   32'(done), 32'd0);
        checkOutput("mul_no_queue_result", result,    32'hFFFF_FFFD);

        applyStimulus(ALU_DIVU, 32'd100, 32'd7);
        waitDone(n);
        checkOutput("divu_latency", 32'(n), 32'd33);
        checkOutput("divu_result",  result, 32'd14);
        applyStimulus(ALU_REMU, 32'd100, 32'd7);
        waitDone(n);
        checkOutput("remu_result", result, 32'd2);
        applyStimulus(ALU_DIVU, 32'h1234_5678, 32'd0);
        waitDone(n);
        checkOutput("divu0_latency", 32'(n), 32'd33);
        checkOutput("divu0_result",  result, 32'hFFFF_FFFF);
        applyStimulus(ALU_REMU, 32'd9, 32'd0);
        waitDone(n);
        checkOutput("remu0_result", result,    32'd9);
        checkOutput("remu0_zero",   32'(zero), 32'd0);
        @(posedge clk);
        #1;

        // Three single-cycle ops accepted on consecutive edges.
        applyStimulus(ALU_ADD, 32'd3, 32'd4);
        checkOutput("b2b_add_done",   32'(done), 32'd1);
        checkOutput("b2b_add_result", result,    32'd7);
        applyStimulus(ALU_OR, 32'h0000_00F0, 32'h0000_000F);
        checkOutput("b2b_or_done",    32'(done), 32'd1);
        checkOutput("b2b_or_result",  result,    32'h0000_00FF);
        applyStimulus(ALU_AND, 32'h0000_00FF, 32'h0000_003C);
        checkOutput("b2b_and_done",   32'(done), 32'd1);
        checkOutput("b2b_and_result", result,    32'h0000_003C);

        applyStimulus(4'h3, 32'd12, 32'd34);
        checkOutput("illegal_done",   32'(done), 32'd1);
        checkOutput("illegal_result", result,    32'd0);
        checkOutput("illegal_zero",   32'(zero), 32'd1);

        applyStimulus(ALU_NOR, 32'd0, 32'd0);
        checkOutput("nor_result", result, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;

        // Reset around iteration 10 of a MUL must abort it with no done pulse.
        applyStimulus(ALU_MUL, 32'd5, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort_result", result,     32'd0);
        checkOutput("abort_zero",   32'(zero),  32'd1);
        checkOutput("abort_ready",  32'(ready), 32'd1);
        checkOutput("abort_done",   32'(done),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sawDone = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            sawDone = sawDone | done;
        end
        checkOutput("abort_no_done", 32'(sawDone), 32'd0);
        checkOutput("abort_idle_ready", 32'(ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
